pcs_loopback_elastic: RTL
=========================

Name: pcs_loopback_elastic

Overview:
Single-clock RX-to-TX PCS loopback for FPGA link testing, generalised over lane count and data width. An elastic FIFO absorbs the mismatch between the RX gearbox output bubbles (rx_valid_i low) and the TX gearbox stall cycles (tx_ready_i low). The FIFO only drains after a start threshold is reached. Above a high-water mark it deletes all-idle blocks, and it substitutes idle blocks on underflow. It sits between the RX PCS decoder output and the TX PCS encoder input, and is enabled at run time.

Parameters:
DATA_W, 64, data bits per lane
LANE_N, 1, number of lanes
LANE0_CNT_N, 1, start-position bits per lane
DEPTH, 8, FIFO entries; power of 2, >=4
START_LVL, 4, fill level at which draining begins; 1..DEPTH
HIGH_LVL, 6, level at or above which all-idle entries are deleted; START_LVL..DEPTH
KEEP_W, DATA_W/8, localparam, keep bits per lane
LVL_W, $clog2(DEPTH)+1, localparam

Ports:
clk  in  1  single clock; RX and TX PCS share it
reset  in  1  asynchronous, active-high reset
loopback_en_i  in  1  1 = loopback active; 0 = disabled, FIFO flushed
rx_valid_i  in  1  RX block valid this cycle
pcs_rx_ctrl_i / idle_i / term_i / err_i  in  LANE_N each  RX flags
pcs_rx_start_i  in  LANE_N*LANE0_CNT_N  start flags
pcs_rx_data_i  in  LANE_N*DATA_W  data
pcs_rx_keep_i  in  LANE_N*KEEP_W  byte keep
tx_ready_i  in  1  TX consumes the current output block at this edge
pcs_tx_ctrl_o / idle_o / term_o / err_o  out  LANE_N each  TX flags
pcs_tx_start_o  out  LANE_N*LANE0_CNT_N
pcs_tx_data_o  out  LANE_N*DATA_W
pcs_tx_keep_o  out  LANE_N*KEEP_W
fifo_lvl_o  out  LVL_W  current occupancy, 0..DEPTH
overflow_o  out  1  sticky: a non-idle block was dropped
underflow_o  out  1  sticky: FIFO ran empty while in RUN

Behaviour:
- IDLE block definition: ctrl=all 1, idle=all 1, term=0, err=0, start=0, data=0, keep=0.
- FIFO entry: all seven RX fields concatenated, LANE_N*(4+LANE0_CNT_N+DATA_W+KEEP_W) bits.
- Pointers: $clog2(DEPTH) bits, natural wrap. fifo_lvl_o is a registered count.
- Reset, and the cycle after it: state DIS, level 0, overflow_o=0, underflow_o=0, outputs = IDLE block.
- Output register: loads only on edges where tx_ready_i=1. Otherwise it holds its value.
- The source for each load is the FIFO head (pop) in RUN when the FIFO is non-empty; in all other cases it is the IDLE block.
- State DIS:
  - Writes are ignored and the level is forced to 0.
  - overflow_o and underflow_o are cleared.
  - Transition to FILL on the first edge with loopback_en_i=1.
- State FILL:
  - Writes are accepted; outputs load IDLE.
  - Transition to RUN on an edge where the level is >= START_LVL and tx_ready_i=1. That same edge pops the head into the output.
- State RUN:
  - Each tx_ready_i=1 edge pops one entry.
  - If the FIFO is empty at a tx_ready_i=1 edge: load IDLE, set underflow_o, return to FILL.
- loopback_en_i=0 in any state forces the next state to DIS. The flush takes effect at that edge and outputs load IDLE regardless of tx_ready_i.
- Write rules, applied only when rx_valid_i=1 and state is not DIS:
  - Deletion: if all LANE_N idle bits are 1 and level >= HIGH_LVL, discard the block silently with no overflow.
  - Otherwise, write if the FIFO is not full, or if it is full and a pop occurs on the same edge.
  - Otherwise, drop the block and set overflow_o.
- Simultaneous push and pop leaves the level unchanged. Level changes by at most ±1 per cycle.
- Latency: in RUN at steady state, a block written at edge N appears on the output no earlier than edge N+1. Read is registered; there is no write-to-read bypass within a cycle.
- Block order is preserved; no data block is ever reordered or duplicated.

Test Plan:
1. Reset asserted mid-RUN with level=5 -> next cycle: level 0, state DIS, outputs IDLE block, sticky flags 0.
2. loopback_en_i=1, tx_ready_i=1, rx_valid_i=1 continuously, data = incrementing counter from 0x1 -> outputs IDLE until level reaches 4, then 0x1, 0x2, ... in order with no gaps; level then holds at 4.
3. RUN, rx_valid_i low 1 cycle in 33 while tx_ready_i=1 -> level slowly decays to 0, then one IDLE output, underflow_o=1, refill to 4, resume in order.
4. tx_ready_i=0 for 10 cycles with non-idle data arriving, DEPTH=8 -> level saturates at 8, the extra 2 blocks are dropped, overflow_o=1, and the 8 stored blocks drain in order.
5. Level=6, an all-idle block arrives with tx_ready_i=0 -> block discarded, level stays 6, overflow_o stays 0. A non-idle block in the same situation is written and level becomes 7.
6. loopback_en_i dropped with level=3 and overflow_o=1 -> next edge: level 0, overflow_o=0, output IDLE. Re-enabling restarts from FILL.

Source files
------------

// File: rtl/pcs_loopback_elastic.sv
// pcs_loopback_elastic: RX->TX PCS loopback with an elastic FIFO on one clock.
// The FIFO fills to START_LVL before draining and deletes all-idle blocks at or
// above HIGH_LVL. When it runs dry in RUN, an IDLE block is sent and it refills.
// Ports: clk/reset, loopback_en_i, and the RX block bus (rx_valid_i plus the
// pcs_rx_* fields). tx_ready_i and the TX block bus (pcs_tx_*) form the output.
// fifo_lvl_o gives occupancy. overflow_o and underflow_o are sticky flags that
// clear when loopback is disabled.
module pcs_loopback_elastic #(
  parameter int DATA_W      = 64,
  parameter int LANE_N      = 1,
  parameter int LANE0_CNT_N = 1,
  parameter int DEPTH       = 8,
  parameter int START_LVL   = 4,
  parameter int HIGH_LVL    = 6,
  localparam int KEEP_W     = DATA_W / 8,
  localparam int LVL_W      = $clog2(DEPTH) + 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          loopback_en_i,
  input  logic                          rx_valid_i,
  input  logic [LANE_N-1:0]             pcs_rx_ctrl_i,
  input  logic [LANE_N-1:0]             pcs_rx_idle_i,
  input  logic [LANE_N-1:0]             pcs_rx_term_i,
  input  logic [LANE_N-1:0]             pcs_rx_err_i,
  input  logic [LANE_N*LANE0_CNT_N-1:0] pcs_rx_start_i,
  input  logic [LANE_N*DATA_W-1:0]      pcs_rx_data_i,
  input  logic [LANE_N*KEEP_W-1:0]      pcs_rx_keep_i,
  input  logic                          tx_ready_i,
  output logic [LANE_N-1:0]             pcs_tx_ctrl_o,
  output logic [LANE_N-1:0]             pcs_tx_idle_o,
  output logic [LANE_N-1:0]             pcs_tx_term_o,
  output logic [LANE_N-1:0]             pcs_tx_err_o,
  output logic [LANE_N*LANE0_CNT_N-1:0] pcs_tx_start_o,
  output logic [LANE_N*DATA_W-1:0]      pcs_tx_data_o,
  output logic [LANE_N*KEEP_W-1:0]      pcs_tx_keep_o,
  output logic [LVL_W-1:0]              fifo_lvl_o,
  output logic                          overflow_o,
  output logic                          underflow_o
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int ENTRY_W = LANE_N * (4 + LANE0_CNT_N + DATA_W + KEEP_W);

  localparam logic [1:0] S_DIS  = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  localparam logic [LVL_W-1:0] START_L = LVL_W'(START_LVL);
  localparam logic [LVL_W-1:0] HIGH_L  = LVL_W'(HIGH_LVL);
  localparam logic [LVL_W-1:0] FULL_L  = LVL_W'(DEPTH);

  // IDLE block: ctrl and idle set on every lane, every other field zero.
  localparam logic [ENTRY_W-1:0] IDLE_ENTRY =
    {{LANE_N{1'b1}}, {LANE_N{1'b1}}, {(ENTRY_W-2*LANE_N){1'b0}}};

  logic [1:0]         state, state_d;
  logic [LVL_W-1:0]   lvl, lvl_d;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic               ovf, udf;
  logic [ENTRY_W-1:0] out_q;
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [ENTRY_W-1:0] rx_entry;

  logic active, run, fill, empty, full;
  logic pop, del, wr_try, push, drop, starve, flush;

  assign rx_entry = {pcs_rx_ctrl_i, pcs_rx_idle_i, pcs_rx_term_i, pcs_rx_err_i,
                     pcs_rx_start_i, pcs_rx_data_i, pcs_rx_keep_i};

  assign run    = (state == S_RUN);
  assign fill   = (state == S_FILL);
  assign empty  = (lvl == '0);
  assign full   = (lvl == FULL_L);
  // A disabled loopback or the DIS state empties the FIFO and clears flags.
  assign flush  = !loopback_en_i || (state == S_DIS);
  assign active = !flush;

  // FILL pops on the same edge that it hands over to RUN.
  assign pop    = active && tx_ready_i && !empty && (run || (fill && lvl >= START_L));
  assign starve = active && run && tx_ready_i && empty;

  // Idle deletion above the high-water mark is silent; it never counts as overflow.
  assign del    = rx_valid_i && (&pcs_rx_idle_i) && (lvl >= HIGH_L);
  assign wr_try = active && rx_valid_i && !del;
  assign push   = wr_try && (!full || pop);
  assign drop   = wr_try && full && !pop;

  always_comb begin
    state_d = state;
    if (!loopback_en_i) begin
      state_d = S_DIS;
    end else begin
      case (state)
        S_DIS:   state_d = S_FILL;
        S_FILL:  if (tx_ready_i && lvl >= START_L) state_d = S_RUN;
        S_RUN:   if (starve) state_d = S_FILL;
        default: state_d = S_DIS;
      endcase
    end
  end

  always_comb begin
    lvl_d = lvl;
    if (push && !pop)      lvl_d = lvl + LVL_W'(1);
    else if (pop && !push) lvl_d = lvl - LVL_W'(1);
  end

  // Storage is not reset; the pointers and the level define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rx_entry;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_DIS;
      lvl    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
      out_q  <= IDLE_ENTRY;
    end else begin
      state <= state_d;
      if (flush) begin
        lvl    <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
        ovf    <= 1'b0;
        udf    <= 1'b0;
      end else begin
        lvl <= lvl_d;
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        ovf <= ovf | drop;
        udf <= udf | starve;
      end
      // Disabling loads IDLE even while TX stalls, so no stale data stays on the bus.
      if (!loopback_en_i)  out_q <= IDLE_ENTRY;
      else if (tx_ready_i) out_q <= pop ? mem[rd_ptr] : IDLE_ENTRY;
    end
  end

  assign {pcs_tx_ctrl_o, pcs_tx_idle_o, pcs_tx_term_o, pcs_tx_err_o,
          pcs_tx_start_o, pcs_tx_data_o, pcs_tx_keep_o} = out_q;

  assign fifo_lvl_o  = lvl;
  assign overflow_o  = ovf;
  assign underflow_o = udf;

endmodule
